// File: rtl/n64_pi_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : n64_pi_sequencer_pkg
// Purpose  : Shared constants and types for the N64 PI slave front end.
//            Holds the PI bus-phase state encoding and the byte step applied
//            to the transfer address after every 16-bit data beat.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package n64_pi_sequencer_pkg;

   // PI bus phase tracked by the sequencer
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ADDR_HIGH = 2'd1,
      ST_ADDR_LOW  = 2'd2,
      ST_DATA      = 2'd3
   } pi_state_e;

   // One PI data beat moves 16 bits, i.e. two bytes of address space
   localparam logic [31:0] PI_ADDR_STEP = 32'd2;

endpackage : n64_pi_sequencer_pkg
`default_nettype wire

// File: rtl/n64_pi_sequencer_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : n64_pi_sync_edge
// Purpose  : Multi-flop synchroniser for one asynchronous strobe, followed by
//            a history register so rising/falling edges can be detected on
//            the synchronised level.
// Ports    : clk_i   - sampling clock
//            rst_i   - synchronous active-high reset (loads RESET_LEVEL)
//            d_i     - raw asynchronous input
//            level_o - synchronised ("current") level
//            prev_o  - level one cycle earlier
//            rise_o  - current=1, previous=0
//            fall_o  - current=0, previous=1
// Revision : 1.0 - initial release
// ============================================================================
module n64_pi_sync_edge #(
   parameter int   SYNC_STAGES = 2,    // must be >= 2
   parameter logic RESET_LEVEL = 1'b0  // inactive bus level of this strobe
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic prev_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Whole chain, history included, is loaded with the inactive level so
   // that releasing reset with the bus idle can never look like an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
         prev_q <= RESET_LEVEL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign prev_o  = prev_q;
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule : n64_pi_sync_edge
`default_nettype wire

// File: rtl/n64_pi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : n64_pi_sequencer
// Purpose  : Front end of the N64 PI slave path. Synchronises the raw PI
//            strobes and AD bus, tracks the bus phase (address high, address
//            low, data) and emits single-cycle op pulses together with
//            cycle-aligned AD data and a running 32-bit byte address.
// Ports    : i_clk             - system clock
//            i_reset           - synchronous active-high reset
//            i_n64_reset       - console reset, active low, asynchronous
//            i_n64_pi_alel     - PI ALE_L, raw
//            i_n64_pi_aleh     - PI ALE_H, raw
//            i_n64_pi_read     - PI /RD, active low, raw
//            i_n64_pi_write    - PI /WR, active low, raw
//            i_n64_pi_ad       - PI AD bus, raw
//            o_n64_pi_ad       - AD aligned with the op pulses
//            o_address_high_op - pulse, AD holds address[31:16]
//            o_address_low_op  - pulse, AD holds address[15:0]
//            o_read_op         - pulse on /RD falling edge (DATA only)
//            o_write_op        - pulse on /WR rising edge (DATA only)
//            o_address         - current transfer byte address
//            o_busy            - bus phase is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module n64_pi_sequencer
   import n64_pi_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES = 2  // must be >= 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_n64_reset,
   input  logic        i_n64_pi_alel,
   input  logic        i_n64_pi_aleh,
   input  logic        i_n64_pi_read,
   input  logic        i_n64_pi_write,
   input  logic [15:0] i_n64_pi_ad,
   output logic [15:0] o_n64_pi_ad,
   output logic        o_address_high_op,
   output logic        o_address_low_op,
   output logic        o_read_op,
   output logic        o_write_op,
   output logic [31:0] o_address,
   output logic        o_busy
);

   // ------------------------------------------------------------------
   // Synchronisers
   // ------------------------------------------------------------------
   logic n64_rst_n_lvl, n64_rst_prev, n64_rst_rise, n64_rst_fall;
   logic rst_eff;

   // Console reset cannot be cleared by the reset it generates, so its
   // synchroniser only listens to the system reset.
   n64_pi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_n64_rst (
      .clk_i   (i_clk),
      .rst_i   (i_reset),
      .d_i     (i_n64_reset),
      .level_o (n64_rst_n_lvl),
      .prev_o  (n64_rst_prev),
      .rise_o  (n64_rst_rise),
      .fall_o  (n64_rst_fall)
   );

   assign rst_eff = i_reset | ~n64_rst_n_lvl;

   logic alel_lvl, alel_prev, alel_rise, alel_fall;
   logic aleh_lvl, aleh_prev, aleh_rise, aleh_fall;
   logic rd_lvl,   rd_prev,   rd_rise,   rd_fall;
   logic wr_lvl,   wr_prev,   wr_rise,   wr_fall;

   n64_pi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_alel (
      .clk_i (i_clk), .rst_i (rst_eff), .d_i (i_n64_pi_alel),
      .level_o (alel_lvl), .prev_o (alel_prev), .rise_o (alel_rise), .fall_o (alel_fall)
   );

   n64_pi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_aleh (
      .clk_i (i_clk), .rst_i (rst_eff), .d_i (i_n64_pi_aleh),
      .level_o (aleh_lvl), .prev_o (aleh_prev), .rise_o (aleh_rise), .fall_o (aleh_fall)
   );

   n64_pi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_rd (
      .clk_i (i_clk), .rst_i (rst_eff), .d_i (i_n64_pi_read),
      .level_o (rd_lvl), .prev_o (rd_prev), .rise_o (rd_rise), .fall_o (rd_fall)
   );

   n64_pi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_wr (
      .clk_i (i_clk), .rst_i (rst_eff), .d_i (i_n64_pi_write),
      .level_o (wr_lvl), .prev_o (wr_prev), .rise_o (wr_rise), .fall_o (wr_fall)
   );

   // Synchroniser taps this block has no use for
   logic unused_sync_taps;
   assign unused_sync_taps = &{1'b0, n64_rst_prev, n64_rst_rise, n64_rst_fall,
                               alel_prev, alel_rise, aleh_prev, aleh_rise,
                               rd_lvl, rd_prev, wr_lvl, wr_prev, wr_fall};

   // AD bus: same depth as the strobes, so the last stage lines up with
   // the "current" strobe sample used for edge detection.
   logic [15:0] ad_pipe_q [SYNC_STAGES];
   logic [15:0] ad_cur;

   always_ff @(posedge i_clk) begin
      if (rst_eff) begin
         for (int i = 0; i < SYNC_STAGES; i++) ad_pipe_q[i] <= 16'd0;
      end else begin
         ad_pipe_q[0] <= i_n64_pi_ad;
         for (int i = 1; i < SYNC_STAGES; i++) ad_pipe_q[i] <= ad_pipe_q[i-1];
      end
   end

   assign ad_cur = ad_pipe_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Bus-phase FSM and address counter
   // ------------------------------------------------------------------
   pi_state_e   state_q, state_d;
   logic [31:0] address_q, address_d;
   logic [15:0] ad_q, ad_d;
   logic        high_op_q, high_op_d;
   logic        low_op_q, low_op_d;
   logic        read_op_q, read_op_d;
   logic        write_op_q, write_op_d;
   logic        wr_inc_pend_q, wr_inc_pend_d;

   logic        ale_both;
   logic [31:0] pend_step;

   assign ale_both  = alel_lvl & aleh_lvl;
   assign pend_step = wr_inc_pend_q ? PI_ADDR_STEP : 32'd0;

   always_ff @(posedge i_clk) begin
      if (rst_eff) begin
         state_q       <= ST_IDLE;
         address_q     <= 32'd0;
         ad_q          <= 16'd0;
         high_op_q     <= 1'b0;
         low_op_q      <= 1'b0;
         read_op_q     <= 1'b0;
         write_op_q    <= 1'b0;
         wr_inc_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         address_q     <= address_d;
         ad_q          <= ad_d;
         high_op_q     <= high_op_d;
         low_op_q      <= low_op_d;
         read_op_q     <= read_op_d;
         write_op_q    <= write_op_d;
         wr_inc_pend_q <= wr_inc_pend_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ad_d          = ad_cur;
      high_op_d     = 1'b0;
      low_op_d      = 1'b0;
      read_op_d     = 1'b0;
      write_op_d    = 1'b0;
      wr_inc_pend_d = 1'b0;
      // A write's increment lands the cycle after its pulse
      address_d     = address_q + pend_step;

      if (ale_both) begin
         // Both ALEs high restarts the sequence from any phase
         state_d = ST_ADDR_HIGH;
      end else begin
         case (state_q)
            ST_ADDR_HIGH: begin
               if (aleh_fall && alel_lvl) begin
                  state_d          = ST_ADDR_LOW;
                  high_op_d        = 1'b1;
                  address_d[31:16] = ad_cur;
               end else if (alel_fall) begin
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR_LOW: begin
               if (alel_fall && !aleh_lvl) begin
                  state_d         = ST_DATA;
                  low_op_d        = 1'b1;
                  address_d[15:0] = {ad_cur[15:1], 1'b0};
               end
            end
            ST_DATA: begin
               read_op_d = rd_fall;
               // Any coincident /RD edge wins over /WR; a /WR rise paired
               // with a /RD rise shares the read's single increment.
               write_op_d    = wr_rise & ~rd_fall & ~rd_rise;
               wr_inc_pend_d = wr_rise & ~rd_rise;
               if (rd_rise) address_d = address_q + pend_step + PI_ADDR_STEP;
            end
            default: ;
         endcase
      end
   end

   assign o_n64_pi_ad       = ad_q;
   assign o_address_high_op = high_op_q;
   assign o_address_low_op  = low_op_q;
   assign o_read_op         = read_op_q;
   assign o_write_op        = write_op_q;
   assign o_address         = address_q;
   assign o_busy            = (state_q != ST_IDLE);

endmodule : n64_pi_sequencer
`default_nettype wire

// File: tb/tb_n64_pi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_pi_sequencer
// Purpose  : Directed self-checking bench for n64_pi_sequencer. Stimulus is
//            driven 1 ns after the rising edge; a monitor on the falling edge
//            records op pulses with the AD/address seen alongside them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64_pi_sequencer;

   localparam int SYNC_STAGES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        n64_rst_n;
   logic        alel, aleh, rd_n, wr_n;
   logic [15:0] ad_in;
   logic [15:0] ad_out;
   logic        high_op, low_op, read_op, write_op, busy;
   logic [31:0] address;

   always #5 clk = ~clk;

   n64_pi_sequencer #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .i_n64_reset       (n64_rst_n),
      .i_n64_pi_alel     (alel),
      .i_n64_pi_aleh     (aleh),
      .i_n64_pi_read     (rd_n),
      .i_n64_pi_write    (wr_n),
      .i_n64_pi_ad       (ad_in),
      .o_n64_pi_ad       (ad_out),
      .o_address_high_op (high_op),
      .o_address_low_op  (low_op),
      .o_read_op         (read_op),
      .o_write_op        (write_op),
      .o_address         (address),
      .o_busy            (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- pulse monitor ----------------
   int          n_high, n_low, n_read, n_write, n_multi;
   logic [15:0] hi_ad, lo_ad;
   logic [31:0] rd_addr [8];
   logic [15:0] wr_ad   [8];
   logic [31:0] wr_addr [8];

   always @(negedge clk) begin
      if (high_op) begin n_high++; hi_ad = ad_out; end
      if (low_op)  begin n_low++;  lo_ad = ad_out; end
      if (read_op) begin rd_addr[n_read & 7] = address; n_read++; end
      if (write_op) begin
         wr_ad[n_write & 7]   = ad_out;
         wr_addr[n_write & 7] = address;
         n_write++;
      end
      if ((int'(high_op === 1'b1) + int'(low_op === 1'b1) +
           int'(read_op === 1'b1) + int'(write_op === 1'b1)) > 1) n_multi++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clr();
      n_high = 0; n_low = 0; n_read = 0; n_write = 0;
   endtask

   task automatic pi_addr(input logic [15:0] hi, input logic [15:0] lo);
      alel = 1'b1; aleh = 1'b1; ad_in = hi; tick(4);
      aleh = 1'b0; tick(4);
      ad_in = lo; tick(4);
      alel = 1'b0; tick(4);
   endtask

   task automatic rd_pulse();
      rd_n = 1'b0; tick(4);
      rd_n = 1'b1; tick(4);
   endtask

   task automatic wr_pulse(input logic [15:0] data);
      ad_in = data; wr_n = 1'b0; tick(4);
      wr_n = 1'b1; tick(4);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; n64_rst_n = 1'b1; alel = 1'b0; aleh = 1'b0;
      rd_n = 1'b1; wr_n = 1'b1; ad_in = 16'h0000;
      n_multi = 0; clr();
      tick(4);
      rst = 1'b0;
      tick(6);
      n_checks++;
      if ({busy, high_op, low_op, read_op, write_op} !== 5'b0 || address !== 32'd0 || ad_out !== 16'd0)
         $display("FAIL reset_outputs: busy=%b ops=%b%b%b%b addr=%h ad=%h, required all 0",
                  busy, high_op, low_op, read_op, write_op, address, ad_out);
      else n_pass++;
      // /RD and /WR activity in IDLE is ignored
      rd_pulse(); wr_pulse(16'hAAAA);
      n_checks++;
      if (n_read !== 0 || n_write !== 0 || address !== 32'd0)
         $display("FAIL idle_strobes: reads=%0d writes=%0d addr=%h, required 0/0/00000000",
                  n_read, n_write, address);
      else n_pass++;
   endtask

   task automatic test_read_burst();
      clr();
      pi_addr(16'h1000, 16'h0040);
      n_checks++;
      if (n_high !== 1 || hi_ad !== 16'h1000)
         $display("FAIL rb_high_op: count=%0d ad=%h, required 1/1000", n_high, hi_ad);
      else n_pass++;
      n_checks++;
      if (n_low !== 1 || lo_ad !== 16'h0040)
         $display("FAIL rb_low_op: count=%0d ad=%h, required 1/0040", n_low, lo_ad);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1 || address !== 32'h1000_0040)
         $display("FAIL rb_addr_loaded: busy=%b addr=%h, required 1/10000040", busy, address);
      else n_pass++;
      // first read with exact pulse latency (SYNC_STAGES+1 = 3 cycles)
      rd_n = 1'b0; tick(2);
      n_checks++;
      if (read_op !== 1'b0) $display("FAIL rb_latency_early: read_op=%b at 2 cycles, required 0", read_op);
      else n_pass++;
      tick(1);
      n_checks++;
      if (read_op !== 1'b1 || address !== 32'h1000_0040)
         $display("FAIL rb_latency: read_op=%b addr=%h at 3 cycles, required 1/10000040", read_op, address);
      else n_pass++;
      tick(1);
      n_checks++;
      if (read_op !== 1'b0) $display("FAIL rb_pulse_width: read_op=%b, required 0", read_op);
      else n_pass++;
      tick(2); rd_n = 1'b1; tick(4);
      rd_pulse(); rd_pulse(); rd_pulse();
      n_checks++;
      if (n_read !== 4 || rd_addr[3] !== 32'h1000_0046)
         $display("FAIL rb_read_count: reads=%0d last_addr=%h, required 4/10000046", n_read, rd_addr[3]);
      else n_pass++;
      n_checks++;
      if (address !== 32'h1000_0048)
         $display("FAIL rb_final_addr: addr=%h, required 10000048", address);
      else n_pass++;
   endtask

   task automatic test_write_burst();
      clr();
      pi_addr(16'h0800, 16'h0000);
      wr_pulse(16'hBEEF);
      wr_pulse(16'h1234);
      n_checks++;
      if (n_write !== 2) $display("FAIL wb_count: writes=%0d, required 2", n_write);
      else n_pass++;
      n_checks++;
      if (wr_ad[0] !== 16'hBEEF || wr_addr[0] !== 32'h0800_0000)
         $display("FAIL wb_first: ad=%h addr=%h, required BEEF/08000000", wr_ad[0], wr_addr[0]);
      else n_pass++;
      n_checks++;
      if (wr_ad[1] !== 16'h1234 || wr_addr[1] !== 32'h0800_0002)
         $display("FAIL wb_second: ad=%h addr=%h, required 1234/08000002", wr_ad[1], wr_addr[1]);
      else n_pass++;
      n_checks++;
      if (address !== 32'h0800_0004 || n_read !== 0)
         $display("FAIL wb_final: addr=%h reads=%0d, required 08000004/0", address, n_read);
      else n_pass++;
   endtask

   task automatic test_odd_address();
      clr();
      pi_addr(16'h1234, 16'h0041);
      n_checks++;
      if (address !== 32'h1234_0040 || lo_ad !== 16'h0041)
         $display("FAIL odd_addr: addr=%h ad=%h, required 12340040/0041", address, lo_ad);
      else n_pass++;
   endtask

   task automatic test_restart();
      clr();
      pi_addr(16'h1000, 16'h0040);
      rd_pulse(); rd_pulse();
      n_checks++;
      if (address !== 32'h1000_0044) $display("FAIL rs_pre: addr=%h, required 10000044", address);
      else n_pass++;
      clr();
      // new ALE sequence; a /RD pulse while both ALEs are high must be ignored
      alel = 1'b1; aleh = 1'b1; ad_in = 16'h2000; tick(4);
      rd_pulse();
      n_checks++;
      if (n_read !== 0 || busy !== 1'b1)
         $display("FAIL rs_addr_high: reads=%0d busy=%b, required 0/1", n_read, busy);
      else n_pass++;
      aleh = 1'b0; tick(4);
      ad_in = 16'h0100; tick(4);
      alel = 1'b0; tick(4);
      n_checks++;
      if (n_high !== 1 || n_low !== 1 || hi_ad !== 16'h2000 || lo_ad !== 16'h0100)
         $display("FAIL rs_ops: high=%0d low=%0d hi=%h lo=%h, required 1/1/2000/0100",
                  n_high, n_low, hi_ad, lo_ad);
      else n_pass++;
      n_checks++;
      if (address !== 32'h2000_0100) $display("FAIL rs_reload: addr=%h, required 20000100", address);
      else n_pass++;
   endtask

   task automatic test_abort_high();
      clr();
      // ALE_L falls while still in the high phase: back to IDLE, no pulses
      alel = 1'b1; aleh = 1'b1; ad_in = 16'h5555; tick(4);
      alel = 1'b0; tick(4);
      aleh = 1'b0; tick(4);
      n_checks++;
      if (busy !== 1'b0 || n_high !== 0 || n_low !== 0)
         $display("FAIL abort_high: busy=%b high=%0d low=%0d, required 0/0/0", busy, n_high, n_low);
      else n_pass++;
   endtask

   task automatic test_wrap();
      clr();
      pi_addr(16'hFFFF, 16'hFFFE);
      rd_pulse();
      n_checks++;
      if (rd_addr[0] !== 32'hFFFF_FFFE || address !== 32'h0000_0000)
         $display("FAIL wrap: read_addr=%h addr=%h, required FFFFFFFE/00000000", rd_addr[0], address);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      clr();
      pi_addr(16'h0300, 16'h0010);
      ad_in = 16'h7777; rd_n = 1'b0; wr_n = 1'b0; tick(4);
      rd_n = 1'b1; wr_n = 1'b1; tick(6);
      n_checks++;
      if (n_read !== 1 || n_write !== 0)
         $display("FAIL simul_ops: reads=%0d writes=%0d, required 1/0", n_read, n_write);
      else n_pass++;
      n_checks++;
      if (address !== 32'h0300_0012) $display("FAIL simul_addr: addr=%h, required 03000012", address);
      else n_pass++;
   endtask

   task automatic test_n64_reset();
      clr();
      pi_addr(16'h4000, 16'h0020);
      rd_pulse();
      n64_rst_n = 1'b0; tick(2);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL n64rst_early: busy=%b after 2 cycles, required 1", busy);
      else n_pass++;
      tick(1);
      n_checks++;
      if (busy !== 1'b0 || address !== 32'd0)
         $display("FAIL n64rst_idle: busy=%b addr=%h after 3 cycles, required 0/00000000", busy, address);
      else n_pass++;
      clr();
      rd_pulse();
      n64_rst_n = 1'b1; tick(4);
      rd_pulse();
      n_checks++;
      if (n_read !== 0 || busy !== 1'b0 || address !== 32'd0)
         $display("FAIL n64rst_after: reads=%0d busy=%b addr=%h, required 0/0/00000000",
                  n_read, busy, address);
      else n_pass++;
   endtask

   task automatic test_sys_reset_pulse();
      clr();
      pi_addr(16'h0ABC, 16'h0100);
      rd_pulse();
      rst = 1'b1; tick(1);
      rst = 1'b0;
      n_checks++;
      if ({busy, high_op, low_op, read_op, write_op} !== 5'b0 || address !== 32'd0 || ad_out !== 16'd0)
         $display("FAIL sysrst_outputs: busy=%b ops=%b%b%b%b addr=%h ad=%h, required all 0",
                  busy, high_op, low_op, read_op, write_op, address, ad_out);
      else n_pass++;
      clr();
      tick(8);
      n_checks++;
      if (n_high + n_low + n_read + n_write !== 0 || busy !== 1'b0)
         $display("FAIL sysrst_release: pulses=%0d busy=%b, required 0/0",
                  n_high + n_low + n_read + n_write, busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_write_burst();
      test_odd_address();
      test_restart();
      test_abort_high();
      test_wrap();
      test_simultaneous();
      test_n64_reset();
      test_sys_reset_pulse();
      n_checks++;
      if (n_multi !== 0) $display("FAIL one_hot_ops: overlapping cycles=%0d, required 0", n_multi);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule : tb_n64_pi_sequencer
`default_nettype wire

// File: doc/n64_pi_sequencer.md
Name: n64_pi_sequencer

Overview:
- Front end of the N64 PI (parallel interface) slave path.
- Synchronises the raw asynchronous PI strobes and AD bus into the FPGA clock domain and tracks the bus phase (address high, address low, data).
- Emits single-cycle op pulses, delay-matched AD data and a running 32-bit byte address.
- Directly feeds n64_bank_decoder (address_high_op, address_low_op, AD) and the downstream read/write data path.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser; must be ≥2.

Ports:
- i_clk  in  1  system clock; the single clock of the block.
- i_reset  in  1  synchronous, active-high reset.
- i_n64_reset  in  1  console reset, active low, asynchronous; synchronised internally.
- i_n64_pi_alel  in  1  PI ALE_L, raw.
- i_n64_pi_aleh  in  1  PI ALE_H, raw.
- i_n64_pi_read  in  1  PI /RD, active low, raw.
- i_n64_pi_write  in  1  PI /WR, active low, raw.
- i_n64_pi_ad  in  16  PI AD bus input, raw.
- o_n64_pi_ad  out  16  AD delayed to align with the op pulses.
- o_address_high_op  out  1  one-cycle pulse; o_n64_pi_ad holds address[31:16].
- o_address_low_op  out  1  one-cycle pulse; o_n64_pi_ad holds address[15:0].
- o_read_op  out  1  one-cycle pulse at /RD assertion (falling edge).
- o_write_op  out  1  one-cycle pulse at /WR deassertion (rising edge); o_n64_pi_ad holds write data.
- o_address  out  32  current transfer byte address; bit 0 is always 0.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Synchronisers:
  - Every raw input, including all 16 AD bits, passes through SYNC_STAGES flops.
  - One further register stage provides the previous value for edge detection.
  - o_n64_pi_ad is taken from the same stage as the "current" strobe sample, so data and op pulses are cycle-aligned.
  - Pulse latency from a raw edge is SYNC_STAGES+1 cycles.
- The effective reset is i_reset OR synchronised i_n64_reset == 0.
- Reset values:
  - State IDLE.
  - All op pulses 0.
  - o_address 0, o_n64_pi_ad 0, o_busy 0.
  - Edge-history registers loaded to the inactive levels: ALEs 0, /RD and /WR 1. This prevents a false edge on reset release.
- States: IDLE, ADDR_HIGH, ADDR_LOW, DATA.
- Transitions:
  - Any state → ADDR_HIGH when the synchronised ALE_H and ALE_L are both 1. This restarts the sequence unconditionally, including from DATA mid-burst.
  - ADDR_HIGH → ADDR_LOW on ALE_H falling while ALE_L is 1:
    - pulse o_address_high_op;
    - o_address[31:16] ← AD.
  - ADDR_LOW → DATA on ALE_L falling while ALE_H is 0:
    - pulse o_address_low_op;
    - o_address[15:0] ← {AD[15:1], 1'b0}.
  - ALE_L falling while in ADDR_HIGH (ALE_H never fell) → IDLE, with no pulses.
  - DATA stays in DATA until the next ALE sequence or reset. There is no timeout.
- DATA phase:
  - /RD falling → pulse o_read_op.
  - /RD rising → o_address += 2.
  - /WR rising → pulse o_write_op, then o_address += 2 in the following cycle. The address update is visible one cycle after the pulse, so consumers use the pre-increment address with the pulse.
  - The address wraps modulo 2^32: 0xFFFF_FFFE + 2 = 0x0000_0000.
- /RD or /WR edges outside DATA are ignored: no pulses, no address change.
- /RD and /WR edges in the same cycle (illegal on the bus):
  - the read pulse wins;
  - o_write_op is suppressed;
  - o_address increments once only.
- At most one of the four op pulses is high in any cycle.
- The pulse order per transaction is: high, then low, then data ops.

Decomposition:
- The state encoding (2-bit enum) and the PI_ADDR_STEP constant (2) belong in the shared constants include, alongside the BANK_* defines.
- One natural sub-module: n64_pi_sync_edge. It is a parameterised SYNC_STAGES synchroniser with reset level, registered previous value and rise/fall outputs. It is instantiated for the ALE_L, ALE_H, /RD and /WR strobes and for n64_reset. The AD bus uses a plain N-bit sync pipeline of equal depth.

Test Plan:
- Full read burst, AD=0x1000 during high phase, 0x0040 during low phase, then 4 /RD pulses:
  - high_op then low_op fire, each aligned with o_n64_pi_ad = 0x1000 / 0x0040;
  - o_address = 0x1000_0040 at the first read_op, 0x1000_0048 after the last /RD rise;
  - exactly 4 read_op pulses.
- Write burst to 0x0800_0000 with 2 /WR pulses, AD=0xBEEF then 0x1234:
  - write_op fires with o_n64_pi_ad = 0xBEEF, then 0x1234;
  - final o_address = 0x0800_0004.
- Low-half AD=0x0041 (odd):
  - o_address[0] = 0;
  - o_address[15:0] = 0x0040.
- New ALE sequence mid-burst after 2 reads:
  - state returns to ADDR_HIGH;
  - fresh high/low ops fire;
  - the address is reloaded from the new AD values, ignoring the old counter.
- o_address at 0xFFFF_FFFE, one /RD cycle: address becomes 0x0000_0000.
- Reset cases:
  - i_n64_reset low during DATA → IDLE within SYNC_STAGES+1 cycles; /RD edges that follow produce no read_op;
  - i_reset asserted for 1 cycle → all outputs 0 the next cycle, with no spurious pulse on release while /RD=/WR=1.
